// File: rtl/std_fp_sdiv_iter.sv
// std_fp_sdiv_iter: multi-cycle signed fixed-point restoring divider, one quotient bit per cycle, go/done handshake.
module std_fp_sdiv_iter #(
  parameter int WIDTH = 32,
  parameter int INT_WIDTH = 16,
  parameter int FRACT_WIDTH = 16
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic             go,
  input  logic [WIDTH-1:0] left,
  input  logic [WIDTH-1:0] right,
  output logic [WIDTH-1:0] out_quotient,
  output logic [WIDTH-1:0] out_remainder,
  output logic             done
);
  localparam int N = INT_WIDTH + 2 * FRACT_WIDTH;
  localparam int CW = $clog2(N);
  localparam logic [CW-1:0] LAST = CW'(N - 1);
  localparam logic [1:0] S_IDLE = 2'd0, S_RUN = 2'd1, S_DONE = 2'd2;
  logic [1:0] state;
  logic [CW-1:0] count;
  logic [N-1:0] dvd;
  logic [WIDTH:0] rem, trial, sub;
  logic [WIDTH-1:0] dsr, abs_l, abs_r, q_res, r_res;
  logic neg_q, neg_r, ge;
  always_comb begin
    abs_l = left[WIDTH-1] ? -left : left;
    abs_r = right[WIDTH-1] ? -right : right;
    trial = {rem[WIDTH-1:0], dvd[N-1]};
    ge = rem[WIDTH] | (trial >= {1'b0, dsr});
    sub = trial - {1'b0, dsr};
    q_res = neg_q ? -dvd[WIDTH-1:0] : dvd[WIDTH-1:0];
    r_res = neg_r ? -rem[WIDTH-1:0] : rem[WIDTH-1:0];
  end
  // dvd holds the shifted dividend and collects quotient bits from the right
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state <= S_IDLE;
      count <= '0;
      dvd <= '0;
      rem <= '0;
      dsr <= '0;
      neg_q <= 1'b0;
      neg_r <= 1'b0;
      out_quotient <= '0;
      out_remainder <= '0;
      done <= 1'b0;
    end else begin
      done <= 1'b0;
      case (state)
        S_IDLE: if (go) begin
          neg_q <= left[WIDTH-1] ^ right[WIDTH-1];
          neg_r <= left[WIDTH-1];
          dsr <= abs_r;
          count <= '0;
          if (right == '0) begin
            dvd <= '0;
            rem <= {1'b0, abs_l};
            state <= S_DONE;
          end else begin
            dvd <= {abs_l, {FRACT_WIDTH{1'b0}}};
            rem <= '0;
            state <= S_RUN;
          end
        end
        S_RUN: begin
          rem <= ge ? sub : trial;
          dvd <= {dvd[N-2:0], ge};
          count <= count + 1'b1;
          if (count == LAST) state <= S_DONE;
        end
        S_DONE: begin
          out_quotient <= q_res;
          out_remainder <= r_res;
          done <= 1'b1;
          state <= S_IDLE;
        end
        default: state <= S_IDLE;
      endcase
    end
  end
endmodule
